sap_bus_arbiter: RTL and testbench

//  Parametrised, registered successor to the SAP combinational bus mux. N_SRC sources
//  (PC, IR, ACC, ALU, memory, ...) request the shared WIDTH-bit bus; the block grants one

---
 rtl/sap_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_sap_bus_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sap_bus_arbiter.sv
// sap_bus_arbiter
//   Registered arbiter for the shared SAP bus. N_SRC sources request a WIDTH-bit bus.
//   Each cycle one source is granted by fixed-priority or round-robin arbitration.
//   The current owner can hold the bus across cycles with lock. The controller can
//   override arbitration through the force path.
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   src_data   packed source data, source i at [i*WIDTH +: WIDTH]
//   req        per-source bus request
//   lock       current owner keeps the bus next cycle
//   force_en   controller override, selects force_sel this cycle
//   force_sel  source index used when force_en=1
//   gnt        registered one-hot grant, zero when idle or forced
//   bus_data   registered bus value
//   bus_valid  bus_data carries granted or validly forced data
//   bus_owner  index of the source currently on the bus
//   sel_err    one-cycle pulse when a forced index is out of range
module sap_bus_arbiter #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned N_SRC       = 5,
  parameter int unsigned SEL_W       = 3,
  parameter int unsigned DEFAULT_SRC = 4,
  parameter int unsigned RR_MODE     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SRC*WIDTH-1:0] src_data,
  input  logic [N_SRC-1:0]       req,
  input  logic                   lock,
  input  logic                   force_en,
  input  logic [SEL_W-1:0]       force_sel,
  output logic [N_SRC-1:0]       gnt,
  output logic [WIDTH-1:0]       bus_data,
  output logic                   bus_valid,
  output logic [SEL_W-1:0]       bus_owner,
  output logic                   sel_err
);

  localparam logic [SEL_W-1:0] DEF_IDX = SEL_W'(DEFAULT_SRC);
  localparam logic [N_SRC-1:0] ONE_HOT = N_SRC'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t             state_q;
  logic [N_SRC-1:0]   gnt_q;
  logic [WIDTH-1:0]   data_q;
  logic               valid_q;
  logic [SEL_W-1:0]   owner_q;
  logic               sel_err_q;
  logic [SEL_W-1:0]   rr_ptr_q;

  logic [SEL_W-1:0]   win_d;
  logic [SEL_W-1:0]   rr_ptr_d;
  logic               force_ok;
  logic               hold;

  // Loop-based mux keeps the source index width independent of the select width.
  function automatic logic [WIDTH-1:0] src_word(input logic [SEL_W-1:0] s);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (SEL_W'(i) == s) r = src_data[i*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  // Winner search. Round-robin starts at rr_ptr and wraps. Fixed priority starts at 0.
  always_comb begin
    logic         found;
    int unsigned  idx;
    int unsigned  nxt;
    found    = 1'b0;
    win_d    = '0;
    rr_ptr_d = rr_ptr_q;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      idx = (RR_MODE != 0) ? int'(rr_ptr_q) + i : i;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!found && req[SEL_W'(idx)]) begin
        found = 1'b1;
        win_d = SEL_W'(idx);
      end
    end
    nxt = int'(win_d) + 1;
    if (nxt >= N_SRC) nxt = 0;
    if (RR_MODE != 0) rr_ptr_d = SEL_W'(nxt);
  end

  assign force_ok = int'(force_sel) < N_SRC;
  // Lock only holds while an arbitrated owner still requests the bus.
  assign hold     = (state_q == OWNED) && lock && req[owner_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      owner_q   <= DEF_IDX;
      sel_err_q <= 1'b0;
      rr_ptr_q  <= '0;
    end else begin
      sel_err_q <= 1'b0;
      if (force_en) begin
        // A forced transfer is not a grant: gnt clears and the FSM returns to IDLE.
        state_q <= IDLE;
        gnt_q   <= '0;
        if (force_ok) begin
          owner_q <= force_sel;
          data_q  <= src_word(force_sel);
          valid_q <= 1'b1;
        end else begin
          owner_q   <= DEF_IDX;
          data_q    <= src_word(DEF_IDX);
          valid_q   <= 1'b0;
          sel_err_q <= 1'b1;
        end
      end else if (hold) begin
        data_q <= src_word(owner_q);
      end else if (|req) begin
        state_q  <= OWNED;
        gnt_q    <= ONE_HOT << win_d;
        owner_q  <= win_d;
        data_q   <= src_word(win_d);
        valid_q  <= 1'b1;
        rr_ptr_q <= rr_ptr_d;
      end else begin
        state_q <= IDLE;
        gnt_q   <= '0;
        owner_q <= DEF_IDX;
        data_q  <= src_word(DEF_IDX);
        valid_q <= 1'b0;
      end
    end
  end

  assign gnt       = gnt_q;
  assign bus_data  = data_q;
  assign bus_valid = valid_q;
  assign bus_owner = owner_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_sap_bus_arbiter.sv
// Bench for sap_bus_arbiter. It uses a round-robin instance driven by a vector table.
// A fixed-priority instance is checked with a hand-written sequence.
module tb_sap_bus_arbiter;

  logic        clk;
  logic        rst;
  logic [39:0] src_data;
  logic [4:0]  req;
  logic        lock;
  logic        force_en;
  logic [2:0]  force_sel;
  logic [4:0]  gnt;
  logic [7:0]  bus_data;
  logic        bus_valid;
  logic [2:0]  bus_owner;
  logic        sel_err;

  logic [4:0]  req_fp;
  logic [4:0]  gnt_fp;
  logic [7:0]  bus_data_fp;
  logic        bus_valid_fp;
  logic [2:0]  bus_owner_fp;
  logic        sel_err_fp;

  int n_cmp;
  int n_err;

  sap_bus_arbiter #(.WIDTH(8), .N_SRC(5), .SEL_W(3), .DEFAULT_SRC(4), .RR_MODE(1)) dut (
    .clk(clk), .rst(rst), .src_data(src_data), .req(req), .lock(lock),
    .force_en(force_en), .force_sel(force_sel), .gnt(gnt), .bus_data(bus_data),
    .bus_valid(bus_valid), .bus_owner(bus_owner), .sel_err(sel_err)
  );

  sap_bus_arbiter #(.WIDTH(8), .N_SRC(5), .SEL_W(3), .DEFAULT_SRC(4), .RR_MODE(0)) dut_fp (
    .clk(clk), .rst(rst), .src_data(src_data), .req(req_fp), .lock(1'b0),
    .force_en(1'b0), .force_sel(3'd0), .gnt(gnt_fp), .bus_data(bus_data_fp),
    .bus_valid(bus_valid_fp), .bus_owner(bus_owner_fp), .sel_err(sel_err_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] req;
    logic       lock;
    logic       fen;
    logic [2:0] fsel;
    logic [4:0] gnt;
    logic       valid;
    logic [2:0] owner;
    logic       err;
    logic [7:0] data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [4:0] r, input logic l, input logic fe, input logic [2:0] fs,
                     input logic [4:0] g, input logic v, input logic [2:0] o,
                     input logic e, input logic [7:0] d);
    vec_t t;
    t.req = r; t.lock = l; t.fen = fe; t.fsel = fs;
    t.gnt = g; t.valid = v; t.owner = o; t.err = e; t.data = d;
    vecs.push_back(t);
  endtask

  task automatic check_rr(input string tag, input logic [4:0] g, input logic v,
                          input logic [2:0] o, input logic e, input logic [7:0] d);
    check({tag, " gnt"},   32'(gnt),       32'(g));
    check({tag, " valid"}, 32'(bus_valid), 32'(v));
    check({tag, " owner"}, 32'(bus_owner), 32'(o));
    check({tag, " err"},   32'(sel_err),   32'(e));
    check({tag, " data"},  32'(bus_data),  32'(d));
  endtask

  task automatic check_fp(input string tag, input logic [4:0] g, input logic [2:0] o,
                          input logic [7:0] d);
    check({tag, " gnt"},   32'(gnt_fp),       32'(g));
    check({tag, " valid"}, 32'(bus_valid_fp), 32'(1));
    check({tag, " owner"}, 32'(bus_owner_fp), 32'(o));
    check({tag, " data"},  32'(bus_data_fp),  32'(d));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    // Source data is fixed: src0..src4 = 11,22,33,44,A5.
    src_data  = {8'hA5, 8'h44, 8'h33, 8'h22, 8'h11};
    req       = '0;
    req_fp    = '0;
    lock      = 1'b0;
    force_en  = 1'b0;
    force_sel = '0;
    rst       = 1'b1;

    // Vectors: req lock fen fsel | gnt valid owner err data
    add(5'b00000, 0, 0, 0, 5'b00000, 0, 4, 0, 8'hA5); // idle drives default source
    add(5'b11111, 0, 0, 0, 5'b00001, 1, 0, 0, 8'h11); // RR rotation 0..4,0
    add(5'b11111, 0, 0, 0, 5'b00010, 1, 1, 0, 8'h22);
    add(5'b11111, 0, 0, 0, 5'b00100, 1, 2, 0, 8'h33);
    add(5'b11111, 0, 0, 0, 5'b01000, 1, 3, 0, 8'h44);
    add(5'b11111, 0, 0, 0, 5'b10000, 1, 4, 0, 8'hA5);
    add(5'b11111, 0, 0, 0, 5'b00001, 1, 0, 0, 8'h11); // ptr now 1
    add(5'b00111, 0, 0, 0, 5'b00010, 1, 1, 0, 8'h22); // ptr 2
    add(5'b00111, 0, 0, 0, 5'b00100, 1, 2, 0, 8'h33); // ptr 3
    add(5'b00111, 1, 0, 0, 5'b00100, 1, 2, 0, 8'h33); // locked on 2
    add(5'b00111, 1, 0, 0, 5'b00100, 1, 2, 0, 8'h33);
    add(5'b00111, 1, 0, 0, 5'b00100, 1, 2, 0, 8'h33);
    add(5'b00111, 0, 0, 0, 5'b00001, 1, 0, 0, 8'h11); // release: search from 3 wraps to 0
    add(5'b00111, 1, 0, 0, 5'b00001, 1, 0, 0, 8'h11); // locked on 0, ptr 1
    add(5'b00111, 1, 1, 3, 5'b00000, 1, 3, 0, 8'h44); // force overrides lock
    add(5'b00111, 1, 1, 6, 5'b00000, 0, 4, 1, 8'hA5); // out-of-range force
    add(5'b00111, 1, 0, 0, 5'b00010, 1, 1, 0, 8'h22); // IDLE ignores lock, ptr 1 kept
    add(5'b00100, 1, 0, 0, 5'b00100, 1, 2, 0, 8'h33); // owner dropped req despite lock
    add(5'b00000, 0, 0, 0, 5'b00000, 0, 4, 0, 8'hA5);
    add(5'b00100, 0, 0, 0, 5'b00100, 1, 2, 0, 8'h33); // ptr 3
    add(5'b00100, 1, 0, 0, 5'b00100, 1, 2, 0, 8'h33); // locked on 2

    #1;
    check_rr("reset", 5'b00000, 0, 4, 0, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      req       = vecs[i].req;
      lock      = vecs[i].lock;
      force_en  = vecs[i].fen;
      force_sel = vecs[i].fsel;
      @(posedge clk);
      #1;
      check_rr($sformatf("v%0d", i), vecs[i].gnt, vecs[i].valid, vecs[i].owner,
               vecs[i].err, vecs[i].data);
    end

    // Asynchronous reset while locked on owner 2: outputs clear before any edge.
    #2;
    rst = 1'b1;
    #1;
    check_rr("midlock_rst", 5'b00000, 0, 4, 0, 8'h00);
    @(negedge clk);
    rst  = 1'b0;
    // rr_ptr is back at 0, so 2 wins over 4. A stale pointer of 3 would pick 4.
    req  = 5'b10100;
    lock = 1'b1;
    @(posedge clk);
    #1;
    check_rr("post_rst", 5'b00100, 1, 2, 0, 8'h33);

    // Fixed-priority instance.
    @(negedge clk);
    req    = '0;
    lock   = 1'b0;
    req_fp = 5'b01010;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check_fp($sformatf("fp_hold%0d", c), 5'b00010, 1, 8'h22);
    end
    @(negedge clk);
    req_fp = 5'b01000;
    @(posedge clk);
    #1;
    check_fp("fp_drop1", 5'b01000, 3, 8'h44);
    @(negedge clk);
    req_fp = 5'b11111;
    @(posedge clk);
    #1;
    check_fp("fp_all", 5'b00001, 0, 8'h11);
    @(posedge clk);
    #1;
    check_fp("fp_all2", 5'b00001, 0, 8'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
